// File: rtl/sram_access_arbiter.sv
// Arbitrates independent write/read request streams onto a single-port SRAM bank and
// returns read lines through a credit-protected FIFO, so backpressure never drops bank data.
module sram_access_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int FETCH_WIDTH = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clk_en,
    input  logic                              flush,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH*FETCH_WIDTH-1:0] wr_data,
    input  logic                              rd_valid,
    output logic                              rd_ready,
    input  logic [ADDR_WIDTH-1:0]             rd_addr,
    output logic                              rd_data_valid,
    input  logic                              rd_data_ready,
    output logic [DATA_WIDTH*FETCH_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0]             mem_addr_in_bank,
    output logic                              mem_cen_in_bank,
    output logic                              mem_wen_in_bank,
    output logic [DATA_WIDTH*FETCH_WIDTH-1:0] mem_data_in_bank,
    input  logic [DATA_WIDTH*FETCH_WIDTH-1:0] mem_data_out_bank
);
    localparam int LINE_W = DATA_WIDTH * FETCH_WIDTH;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = OCC_W + 1;

    logic [LINE_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [OCC_W-1:0]  r_occ;
    logic              r_inflight;
    logic              r_prio;
    logic              r_live;

    logic              w_active;
    logic              w_has_data;
    logic              w_pop;
    logic              w_push;
    logic [SUM_W-1:0]  w_pending;
    logic              w_credit;
    logic              w_wr_elig;
    logic              w_rd_elig;
    logic              w_wr_gnt;
    logic              w_rd_gnt;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    // Credit accounting and grant selection; r_live drops with rst_n so no grant leaks out in reset.
    always_comb begin
        w_active   = clk_en & ~flush & r_live;
        w_has_data = (r_occ != OCC_W'(0));
        w_pop      = w_active & w_has_data & rd_data_ready;
        w_push     = r_inflight & ~flush;
        w_pending  = SUM_W'(r_occ) + SUM_W'(r_inflight) - SUM_W'(w_pop);
        w_credit   = (w_pending < SUM_W'(FIFO_DEPTH));
        w_wr_elig  = w_active & wr_valid;
        w_rd_elig  = w_active & rd_valid & w_credit;
        w_wr_gnt   = w_wr_elig & (~w_rd_elig | ~r_prio);
        w_rd_gnt   = w_rd_elig & (~w_wr_elig | r_prio);
    end

    // Handshake and bank drive, all decoded from the grant.
    always_comb begin
        wr_ready        = w_wr_gnt;
        rd_ready        = w_rd_gnt;
        rd_data_valid   = w_active & w_has_data;
        mem_cen_in_bank = w_wr_gnt | w_rd_gnt;
        mem_wen_in_bank = w_wr_gnt;
        if (w_wr_gnt) begin
            mem_addr_in_bank = wr_addr;
            mem_data_in_bank = wr_data;
        end else if (w_rd_gnt) begin
            mem_addr_in_bank = rd_addr;
            mem_data_in_bank = {LINE_W{1'b0}};
        end else begin
            mem_addr_in_bank = {ADDR_WIDTH{1'b0}};
            mem_data_in_bank = {LINE_W{1'b0}};
        end
        if (w_has_data) begin
            rd_data = r_fifo[r_rptr];
        end else begin
            rd_data = {LINE_W{1'b0}};
        end
    end

    // Arbitration state, in-flight tracking and the return FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live     <= 1'b0;
            r_wptr     <= {PTR_W{1'b0}};
            r_rptr     <= {PTR_W{1'b0}};
            r_occ      <= {OCC_W{1'b0}};
            r_inflight <= 1'b0;
            r_prio     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= {LINE_W{1'b0}};
            end
        end else if (flush) begin
            r_live     <= 1'b1;
            r_wptr     <= {PTR_W{1'b0}};
            r_rptr     <= {PTR_W{1'b0}};
            r_occ      <= {OCC_W{1'b0}};
            r_inflight <= 1'b0;
            r_prio     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_fifo[r_wptr] <= mem_data_out_bank;
                r_wptr         <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            // With clk_en low the grant is 0: a line captured this cycle moves from
            // in-flight into the FIFO count, so the pending total stays the same.
            r_inflight <= w_rd_gnt;
            if (w_wr_elig & w_rd_elig) begin
                r_prio <= ~r_prio;
            end
        end
    end
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter with a behavioural single-port SRAM bank.
module tb_sram_access_arbiter;
    localparam int DW = 16;
    localparam int FW = 4;
    localparam int AW = 8;
    localparam int FD = 2;
    localparam int LW = DW * FW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_en;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid;
    logic          rd_data_ready;
    logic [LW-1:0] rd_data;
    logic [AW-1:0] mem_addr_in_bank;
    logic          mem_cen_in_bank;
    logic          mem_wen_in_bank;
    logic [LW-1:0] mem_data_in_bank;
    logic [LW-1:0] mem_data_out_bank;

    int            errors = 0;
    int            checks = 0;
    logic [LW-1:0] exp_q [$];
    logic [LW-1:0] exp_line;
    logic [LW-1:0] shadow [256];
    logic [LW-1:0] sram [256];
    logic [LW-1:0] sram_dout;

    sram_access_arbiter #(
        .DATA_WIDTH(DW), .FETCH_WIDTH(FW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
        .mem_addr_in_bank(mem_addr_in_bank), .mem_cen_in_bank(mem_cen_in_bank),
        .mem_wen_in_bank(mem_wen_in_bank), .mem_data_in_bank(mem_data_in_bank),
        .mem_data_out_bank(mem_data_out_bank)
    );

    always #5 clk = ~clk;

    // Single-port bank: write on cen&wen, read data appears the cycle after cen&~wen.
    always @(posedge clk) begin
        if (mem_cen_in_bank) begin
            if (mem_wen_in_bank) sram[mem_addr_in_bank] <= mem_data_in_bank;
            else                 sram_dout <= sram[mem_addr_in_bank];
        end
    end
    assign mem_data_out_bank = sram_dout;

    // Scoreboard: pop on output handshake, push expected line on read grant.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (rd_data_valid && rd_data_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: rd_data=%h emitted, expected no output", rd_data);
                end else begin
                    exp_line = exp_q.pop_front();
                    if (rd_data !== exp_line) begin
                        errors++;
                        $display("FAIL sb_data: rd_data=%h, expected %h", rd_data, exp_line);
                    end
                end
            end
            if (wr_valid && wr_ready) shadow[wr_addr] = wr_data;
            if (rd_valid && rd_ready) exp_q.push_back(shadow[rd_addr]);
        end
        checks++;
        if (mem_cen_in_bank !== (wr_ready | rd_ready) || mem_wen_in_bank !== wr_ready ||
            (wr_ready && rd_ready) || (wr_ready && !wr_valid) || (rd_ready && !rd_valid)) begin
            errors++;
            $display("FAIL grant_consistency: wr_v/r=%b%b rd_v/r=%b%b cen=%b wen=%b",
                     wr_valid, wr_ready, rd_valid, rd_ready, mem_cen_in_bank, mem_wen_in_bank);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [LW-1:0] mk_line(input int i);
        logic [15:0] b = 16'(i);
        return {16'hD000 ^ b, 16'hC000 ^ (b << 2), 16'hB000 ^ (b << 4), 16'hA000 ^ (b << 6)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        rd_data_ready = 1'b1;
        while ((exp_q.size() != 0 || rd_data_valid) && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: %0d lines pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; rd_data_ready = 1'b1;
        wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 8'h55; rd_addr = 8'h55;
        wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #3;
        checks++;
        if ({wr_ready, rd_ready, mem_cen_in_bank, mem_wen_in_bank, mem_addr_in_bank,
             mem_data_in_bank, rd_data_valid, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected all zero",
                     {wr_ready, rd_ready, mem_cen_in_bank, mem_wen_in_bank, mem_addr_in_bank,
                      mem_data_in_bank, rd_data_valid, rd_data});
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (rd_data_valid !== 1'b0 || mem_cen_in_bank !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rd_data_valid=%b cen=%b, expected 0 0", rd_data_valid, mem_cen_in_bank);
        end
    endtask

    task automatic test_write_read();
        logic [LW-1:0] line = 64'hDDDD_CCCC_BBBB_AAAA;
        wr_valid = 1'b1; wr_addr = 8'h12; wr_data = line;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || mem_cen_in_bank !== 1'b1 || mem_wen_in_bank !== 1'b1 ||
            mem_addr_in_bank !== 8'h12 || mem_data_in_bank !== line) begin
            errors++;
            $display("FAIL wr_access: rdy=%b cen=%b wen=%b addr=%h data=%h, expected 1 1 1 12 %h",
                     wr_ready, mem_cen_in_bank, mem_wen_in_bank, mem_addr_in_bank, mem_data_in_bank, line);
        end
        step();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 8'h12;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b1 || mem_cen_in_bank !== 1'b1 || mem_wen_in_bank !== 1'b0 ||
            mem_addr_in_bank !== 8'h12) begin
            errors++;
            $display("FAIL rd_access: rdy=%b cen=%b wen=%b addr=%h, expected 1 1 0 12",
                     rd_ready, mem_cen_in_bank, mem_wen_in_bank, mem_addr_in_bank);
        end
        step();
        rd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_latency_early: rd_data_valid=%b at N+1, expected 0", rd_data_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== line) begin
            errors++;
            $display("FAIL rd_latency_data: valid=%b data=%h at N+2, expected 1 %h", rd_data_valid, rd_data, line);
        end
        step();
        drain("write_read");
    endtask

    task automatic test_contention();
        int   wi = 0;
        int   ri = 0;
        logic exp_w;
        for (int c = 0; c < 5; c++) begin
            wr_valid = 1'b1; rd_valid = 1'b1;
            wr_addr = 8'h30 + 8'(wi); wr_data = mk_line(100 + wi);
            rd_addr = 8'h30 + 8'(ri);
            @(negedge clk);
            exp_w = (c % 2 == 0);
            checks++;
            if (wr_ready !== exp_w || rd_ready !== ~exp_w) begin
                errors++;
                $display("FAIL contention_c%0d: wr_ready=%b rd_ready=%b, expected %b %b",
                         c, wr_ready, rd_ready, exp_w, ~exp_w);
            end
            if (wr_ready) wi++;
            if (rd_ready) ri++;
            step();
        end
        drain("contention");
    endtask

    task automatic test_backpressure();
        int granted = 0;
        int ri = 0;
        rd_data_ready = 1'b0; rd_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rd_addr = 8'h30 + 8'(ri % 3);
            @(negedge clk);
            if (rd_ready) begin granted++; ri++; end
            step();
        end
        rd_addr = 8'h30 + 8'(ri % 3);
        checks++;
        if (granted != 2 || rd_ready !== 1'b0 || rd_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: granted=%0d rd_ready=%b valid=%b, expected 2 0 1", granted, rd_ready, rd_data_valid);
        end
        rd_data_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rd_addr = 8'h30 + 8'(ri % 3);
            @(negedge clk);
            checks++;
            if (rd_ready !== 1'b1 || rd_data_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_resume_c%0d: rd_ready=%b valid=%b, expected 1 1", c, rd_ready, rd_data_valid);
            end
            if (rd_ready) ri++;
            step();
        end
        drain("backpressure");
    endtask

    task automatic test_throughput();
        logic exp_v;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_addr = 8'(i); wr_data = mk_line(200 + i);
            @(negedge clk);
            checks++;
            if (wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL tp_write_%0d: wr_ready=%b, expected 1", i, wr_ready);
            end
            step();
        end
        wr_valid = 1'b0; rd_data_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            rd_valid = (c < 8); rd_addr = 8'(c);
            @(negedge clk);
            exp_v = (c >= 2 && c <= 9);
            checks++;
            if (rd_ready !== (c < 8) || rd_data_valid !== exp_v) begin
                errors++;
                $display("FAIL tp_c%0d: rd_ready=%b valid=%b, expected %b %b", c, rd_ready, rd_data_valid, (c < 8), exp_v);
            end
            step();
        end
        drain("throughput");
    endtask

    task automatic test_clken_flush();
        int ri = 0;
        rd_data_ready = 1'b1; rd_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            clk_en = !(c >= 2 && c <= 4);
            rd_addr = 8'(ri);
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                checks++;
                if (mem_cen_in_bank !== 1'b0 || rd_data_valid !== 1'b0 || rd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL clken_hold_c%0d: cen=%b valid=%b rd_ready=%b, expected 0 0 0",
                             c, mem_cen_in_bank, rd_data_valid, rd_ready);
                end
            end
            if (c == 5) begin
                checks++;
                if (rd_data_valid !== 1'b1 || rd_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL clken_resume: valid=%b rd_ready=%b, expected 1 1", rd_data_valid, rd_ready);
                end
            end
            if (rd_ready) ri++;
            step();
        end
        clk_en = 1'b1;
        drain("clken");
        rd_data_ready = 1'b0; rd_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            rd_addr = 8'(c);
            step();
        end
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b0 || mem_cen_in_bank !== 1'b0 || rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: rd_ready=%b cen=%b valid=%b, expected 0 0 0", rd_ready, mem_cen_in_bank, rd_data_valid);
        end
        step();
        flush = 1'b0; rd_valid = 1'b0; rd_data_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rd_data_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_stale_c%0d: rd_data_valid=%b, expected 0", c, rd_data_valid);
            end
            step();
        end
        rd_valid = 1'b1; rd_addr = 8'd5;
        @(negedge clk);
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_recover: rd_ready=%b, expected 1", rd_ready);
        end
        step();
        drain("flush");
    endtask

    task automatic test_async_reset();
        rd_data_ready = 1'b1; rd_valid = 1'b1; rd_addr = 8'd3;
        step();
        rd_addr = 8'd4;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_ready, rd_ready, mem_cen_in_bank, mem_wen_in_bank, mem_addr_in_bank,
             mem_data_in_bank, rd_data_valid, rd_data} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: rd_ready=%b cen=%b valid=%b, expected all zero",
                     rd_ready, mem_cen_in_bank, rd_data_valid);
        end
        @(negedge clk);
        rd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rd_data_valid !== 1'b0) begin
                errors++;
                $display("FAIL async_reset_stale_c%0d: rd_data_valid=%b, expected 0", c, rd_data_valid);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_backpressure();
        test_throughput();
        test_clken_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
